pipe_sched: RTL and testbench

Pipeline hold/flush scheduler for the five-stage core, replacing the single-source hold decode with a prioritised multi-source stall/flush controller plus an interrupt-entry sequencer. It combines bus wait, multi-cycle EX busy, EX redirects and ID load-use hazards into per-stage hold and flush enables. It drains the pipe before redirecting to the trap vector. It sits beside the pipeline registers and drives the PC register, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_sched_pkg.sv | 37 +++
 rtl/pipe_sched_wdog.sv | 35 +++
 rtl/pipe_sched.sv | 174 +++++++++++++++++
 tb/tb_pipe_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sched_pkg.sv
// pipe_sched_pkg: shared constants for the pipeline hold/flush scheduler.
// Holds the stage bit indices, the 2-bit FSM state encoding, the reset
// polarity constants and the per-source hold/flush patterns.
package pipe_sched_pkg;

  // Bit positions within hold_en_o / flush_en_o
  localparam int STAGE_PC    = 0;
  localparam int STAGE_IFID  = 1;
  localparam int STAGE_IDEX  = 2;
  localparam int STAGE_EXMEM = 3;
  localparam int STAGE_MEMWB = 4;
  localparam int NSTAGE      = 5;

  // Reset is active-high even though the port is called rstn
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } sched_state_e;

  // Hold/flush patterns per stall source, bit4..bit0 = MEM/WB..PC
  localparam logic [NSTAGE-1:0] PAT_NONE   = 5'b00000;
  localparam logic [NSTAGE-1:0] HOLD_MEMW  = 5'b01111;
  localparam logic [NSTAGE-1:0] FLUSH_MEMW = 5'b10000;
  localparam logic [NSTAGE-1:0] HOLD_EXB   = 5'b00111;
  localparam logic [NSTAGE-1:0] FLUSH_EXB  = 5'b01000;
  localparam logic [NSTAGE-1:0] FLUSH_JMP  = 5'b00110;
  localparam logic [NSTAGE-1:0] HOLD_LU    = 5'b00011;
  localparam logic [NSTAGE-1:0] FLUSH_LU   = 5'b00100;

  // Drain counter value on the last of the three clean cycles
  localparam logic [1:0] DRAIN_LAST = 2'd2;

endpackage

// File: rtl/pipe_sched_wdog.sv
// pipe_sched_wdog: consecutive-stall watchdog for pipe_sched.
// Ports: i_clk, i_rst (sync, active-high), i_stall (bus wait or EX busy),
//        o_pulse (one cycle, in the cycle after the count reaches LIMIT).
module pipe_sched_wdog
  import pipe_sched_pkg::*;
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stall,
  output logic o_pulse
);

  logic [W-1:0] r_cnt;
  logic         w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT[W-1:0]);

  // The count clears after firing so a long stall produces one pulse per
  // LIMIT+1 cycles rather than a level.
  always_ff @(posedge i_clk) begin
    if (i_rst == RstEnable) begin
      r_cnt <= '0;
    end else if (w_at_limit || !i_stall) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_pulse = w_at_limit;

endmodule

// File: rtl/pipe_sched.sv
// pipe_sched: prioritised stall/flush controller and interrupt-entry sequencer
// for the five-stage core. Optional watchdog under macro PIPE_SCHED_WDOG_EN.
// Ports: clk, rstn (sync, active-high); stall sources mem_wait_i,
//   ex_hold_flag_i, ex_jump_flag_i/ex_jump_addr_i, id_load_use_i; if_pc_i,
//   irq_req_i, trap_vec_i in. hold_en_o/flush_en_o (bit0 PC..bit4 MEM/WB),
//   jump_flag_o/jump_addr_o (combinational), irq_ack_o/irq_epc_o (registered),
//   wdog_timeout_o out.
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WDOG_LIMIT = 255,
  parameter int unsigned WDOG_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_wait_i,
  input  logic              ex_hold_flag_i,
  input  logic              ex_jump_flag_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              id_load_use_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  output logic [NSTAGE-1:0] hold_en_o,
  output logic [NSTAGE-1:0] flush_en_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              irq_ack_o,
  output logic [ADDR_W-1:0] irq_epc_o,
  output logic              wdog_timeout_o
);

  if (WDOG_W < $clog2(WDOG_LIMIT + 1)) begin : g_wdog_cfg_check
    $error("pipe_sched: WDOG_W too narrow for WDOG_LIMIT");
  end

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [1:0]        r_drain_cnt;
  logic [1:0]        w_drain_cnt_nxt;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] w_epc_nxt;
  logic              r_irq_ack;

  logic              w_stall;
  logic [NSTAGE-1:0] w_pri_hold;
  logic [NSTAGE-1:0] w_pri_flush;
  logic              w_pri_jump;
  logic [NSTAGE-1:0] w_hold;
  logic [NSTAGE-1:0] w_flush;
  logic              w_jump;
  logic [ADDR_W-1:0] w_jump_addr;
  logic              w_in_rst;

  assign w_in_rst = (rstn == RstEnable);
  assign w_stall  = mem_wait_i | ex_hold_flag_i;

  // Fixed-priority stall decode; only the highest active source is honoured.
  always_comb begin
    w_pri_hold  = PAT_NONE;
    w_pri_flush = PAT_NONE;
    w_pri_jump  = 1'b0;
    if (mem_wait_i) begin
      w_pri_hold  = HOLD_MEMW;
      w_pri_flush = FLUSH_MEMW;
    end else if (ex_hold_flag_i) begin
      w_pri_hold  = HOLD_EXB;
      w_pri_flush = FLUSH_EXB;
    end else if (ex_jump_flag_i) begin
      w_pri_flush = FLUSH_JMP;
      w_pri_jump  = 1'b1;
    end else if (id_load_use_i) begin
      w_pri_hold  = HOLD_LU;
      w_pri_flush = FLUSH_LU;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_epc_nxt       = r_epc;
    w_hold          = w_pri_hold;
    w_flush         = w_pri_flush;
    w_jump          = w_pri_jump;
    w_jump_addr     = w_pri_jump ? ex_jump_addr_i : '0;

    unique case (r_state)
      ST_IDLE: begin
        if (irq_req_i && !w_stall) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = 2'd0;
          // A jump resolving in the same cycle means if_pc_i is a wrong-path
          // PC; the handler must return to the jump target instead.
          w_epc_nxt       = w_pri_jump ? ex_jump_addr_i : if_pc_i;
        end
      end

      ST_DRAIN: begin
        // Keep fetch closed so the pipe empties behind the interrupt point.
        w_hold[STAGE_PC]    = 1'b1;
        w_flush[STAGE_IFID] = 1'b1;
        // A jump still kills the wrong-path instructions, but the PC
        // redirect is deferred: the target becomes the return address.
        w_jump              = 1'b0;
        w_jump_addr         = '0;
        if (w_pri_jump) begin
          w_epc_nxt = ex_jump_addr_i;
        end
        if (!w_stall && !id_load_use_i) begin
          if (r_drain_cnt == DRAIN_LAST) begin
            w_state_nxt     = ST_TRAP;
            w_drain_cnt_nxt = 2'd0;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + 2'd1;
          end
        end
      end

      ST_TRAP: begin
        w_hold      = PAT_NONE;
        w_flush     = FLUSH_JMP;
        w_jump      = 1'b1;
        w_jump_addr = trap_vec_i;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 2'd0;
      r_epc       <= '0;
      r_irq_ack   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_epc       <= w_epc_nxt;
      r_irq_ack   <= (r_state == ST_TRAP);
    end
  end

  assign hold_en_o   = w_in_rst ? PAT_NONE : w_hold;
  assign flush_en_o  = w_in_rst ? PAT_NONE : w_flush;
  assign jump_flag_o = w_in_rst ? 1'b0 : w_jump;
  assign jump_addr_o = w_in_rst ? '0 : w_jump_addr;
  assign irq_ack_o   = r_irq_ack;
  assign irq_epc_o   = r_epc;

`ifdef PIPE_SCHED_WDOG_EN
  logic w_wdog_pulse;

  pipe_sched_wdog #(
    .LIMIT (WDOG_LIMIT),
    .W     (WDOG_W)
  ) u_wdog (
    .i_clk   (clk),
    .i_rst   (rstn),
    .i_stall (w_stall),
    .o_pulse (w_wdog_pulse)
  );

  assign wdog_timeout_o = w_in_rst ? 1'b0 : w_wdog_pulse;
`else
  assign wdog_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed vectors for pipe_sched with a queue-based scoreboard.
// Each vector pushes its hand-computed response; the negedge monitor pops and
// compares. Watchdog expectations depend on PIPE_SCHED_WDOG_EN.
module tb_pipe_sched;

  localparam int AW = 32;
`ifdef PIPE_SCHED_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam logic [AW-1:0] TV = 32'h0000_1000;

  localparam logic [4:0] Z     = 5'b00000;
  localparam logic [4:0] H_MW  = 5'b01111;
  localparam logic [4:0] F_MW  = 5'b10000;
  localparam logic [4:0] H_EB  = 5'b00111;
  localparam logic [4:0] F_EB  = 5'b01000;
  localparam logic [4:0] F_J   = 5'b00110;
  localparam logic [4:0] H_LU  = 5'b00011;
  localparam logic [4:0] F_LU  = 5'b00100;
  localparam logic [4:0] H_DR  = 5'b00001;
  localparam logic [4:0] F_DR  = 5'b00010;
  localparam logic [4:0] F_DRW = 5'b10010;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mem_wait_i;
  logic          ex_hold_flag_i;
  logic          ex_jump_flag_i;
  logic [AW-1:0] ex_jump_addr_i;
  logic          id_load_use_i;
  logic [AW-1:0] if_pc_i;
  logic          irq_req_i;
  logic [AW-1:0] trap_vec_i;
  logic [4:0]    hold_en_o;
  logic [4:0]    flush_en_o;
  logic          jump_flag_o;
  logic [AW-1:0] jump_addr_o;
  logic          irq_ack_o;
  logic [AW-1:0] irq_epc_o;
  logic          wdog_timeout_o;

  always #5 clk = ~clk;

  pipe_sched #(
    .ADDR_W     (AW),
    .WDOG_LIMIT (5),
    .WDOG_W     (8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_wait_i     (mem_wait_i),
    .ex_hold_flag_i (ex_hold_flag_i),
    .ex_jump_flag_i (ex_jump_flag_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .id_load_use_i  (id_load_use_i),
    .if_pc_i        (if_pc_i),
    .irq_req_i      (irq_req_i),
    .trap_vec_i     (trap_vec_i),
    .hold_en_o      (hold_en_o),
    .flush_en_o     (flush_en_o),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .irq_ack_o      (irq_ack_o),
    .irq_epc_o      (irq_epc_o),
    .wdog_timeout_o (wdog_timeout_o)
  );

  typedef struct {
    int            id;
    logic [4:0]    hold;
    logic [4:0]    flush;
    logic          jf;
    logic [AW-1:0] ja;
    logic          ack;
    logic [AW-1:0] epc;
    logic          wd;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic cmp(input string nm, input int id, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h required %h", nm, id, act, req);
    end
  endtask

  // Monitor: outputs for a vector are stable by the following negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      cmp("hold_en", m_e.id, AW'(hold_en_o), AW'(m_e.hold));
      cmp("flush_en", m_e.id, AW'(flush_en_o), AW'(m_e.flush));
      cmp("jump_flag", m_e.id, AW'(jump_flag_o), AW'(m_e.jf));
      if (m_e.jf) cmp("jump_addr", m_e.id, jump_addr_o, m_e.ja);
      cmp("irq_ack", m_e.id, AW'(irq_ack_o), AW'(m_e.ack));
      cmp("irq_epc", m_e.id, irq_epc_o, m_e.epc);
      cmp("wdog", m_e.id, AW'(wdog_timeout_o), AW'(m_e.wd));
    end
  end

  // Drive one cycle of inputs and queue its expected response.
  task automatic vec(input logic r, input logic mw, input logic eh, input logic ej,
                     input logic [AW-1:0] ja, input logic lu, input logic irq,
                     input logic [AW-1:0] pc, input logic [4:0] e_hold,
                     input logic [4:0] e_flush, input logic e_jf,
                     input logic [AW-1:0] e_ja, input logic e_ack,
                     input logic [AW-1:0] e_epc, input logic e_wd);
    exp_t e;
    @(posedge clk);
    #1;
    rstn           = r;
    mem_wait_i     = mw;
    ex_hold_flag_i = eh;
    ex_jump_flag_i = ej;
    ex_jump_addr_i = ja;
    id_load_use_i  = lu;
    irq_req_i      = irq;
    if_pc_i        = pc;
    e.id    = vec_id;
    e.hold  = e_hold;
    e.flush = e_flush;
    e.jf    = e_jf;
    e.ja    = e_ja;
    e.ack   = e_ack;
    e.epc   = e_epc;
    e.wd    = e_wd;
    q.push_back(e);
    vec_id++;
  endtask

  initial begin
    rstn           = 1'b1;
    mem_wait_i     = 1'b0;
    ex_hold_flag_i = 1'b0;
    ex_jump_flag_i = 1'b0;
    ex_jump_addr_i = '0;
    id_load_use_i  = 1'b0;
    if_pc_i        = '0;
    irq_req_i      = 1'b0;
    trap_vec_i     = TV;

    // Reset forces combinational outputs low even with inputs active
    vec(1,1,0,1,32'h40,0,1,32'h80,  Z,Z,0,0,  0,0,0);
    vec(1,1,1,1,32'h40,1,1,32'h80,  Z,Z,0,0,  0,0,0);
    // mem_wait beats jump, then the jump goes through
    vec(0,1,0,1,32'h40,0,0,0,  H_MW,F_MW,0,0,  0,0,0);
    vec(0,0,0,1,32'h40,0,0,0,  Z,F_J,1,32'h40,  0,0,0);
    // Load-use alone, then four cycles of EX busy
    vec(0,0,0,0,0,1,0,0,  H_LU,F_LU,0,0,  0,0,0);
    for (int i = 0; i < 4; i++) vec(0,0,1,0,0,0,0,0,  H_EB,F_EB,0,0,  0,0,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,0,0);
    // Jump beats load-use
    vec(0,0,0,1,32'h44,1,0,0,  Z,F_J,1,32'h44,  0,0,0);

    // Clean IRQ entry: request at N, TRAP at N+4, ack at N+5; irq drops early
    vec(0,0,0,0,0,0,1,32'h80,  Z,Z,0,0,  0,0,0);
    for (int i = 0; i < 3; i++) vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'h80,0);
    vec(0,0,0,0,0,0,0,0,  Z,F_J,1,TV,  0,32'h80,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  1,32'h80,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,32'h80,0);

    // Jump during DRAIN: redirect suppressed, becomes the return PC
    vec(0,0,0,0,0,0,1,32'h90,  Z,Z,0,0,  0,32'h80,0);
    vec(0,0,0,1,32'h200,0,0,0,  H_DR,F_J,0,0,  0,32'h90,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'h200,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'h200,0);
    vec(0,0,0,0,0,0,0,0,  Z,F_J,1,TV,  0,32'h200,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  1,32'h200,0);

    // Two mem_wait cycles in DRAIN delay TRAP by two cycles
    vec(0,0,0,0,0,0,1,32'hA0,  Z,Z,0,0,  0,32'h200,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'hA0,0);
    vec(0,1,0,0,0,0,0,0,  H_MW,F_DRW,0,0,  0,32'hA0,0);
    vec(0,1,0,0,0,0,0,0,  H_MW,F_DRW,0,0,  0,32'hA0,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'hA0,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'hA0,0);
    vec(0,0,0,0,0,0,0,0,  Z,F_J,1,TV,  0,32'hA0,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  1,32'hA0,0);

    // Reset mid-DRAIN: back to IDLE, epc cleared, no ack ever
    vec(0,0,0,0,0,0,1,32'hB0,  Z,Z,0,0,  0,32'hA0,0);
    vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'hB0,0);
    vec(1,0,0,0,0,0,0,0,  Z,Z,0,0,  0,32'hB0,0);
    for (int i = 0; i < 3; i++) vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,0,0);

    // Request with a same-cycle jump: jump issued, epc is the target
    vec(0,0,0,1,32'h300,0,1,32'hC0,  Z,F_J,1,32'h300,  0,0,0);
    for (int i = 0; i < 3; i++) vec(0,0,0,0,0,0,0,0,  H_DR,F_DR,0,0,  0,32'h300,0);
    vec(0,0,0,0,0,0,0,0,  Z,F_J,1,TV,  0,32'h300,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  1,32'h300,0);
    // Request blocked by mem_wait stays in IDLE
    vec(0,1,0,0,0,0,1,32'hD0,  H_MW,F_MW,0,0,  0,32'h300,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,32'h300,0);

    // Watchdog (limit 5): 7-cycle hold gives one pulse on the 6th cycle
    for (int i = 0; i < 7; i++) vec(0,0,1,0,0,0,0,0,  H_EB,F_EB,0,0,  0,32'h300,WD && (i == 5));
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,32'h300,0);
    // 4-cycle hold gives none
    for (int i = 0; i < 4; i++) vec(0,0,1,0,0,0,0,0,  H_EB,F_EB,0,0,  0,32'h300,0);
    vec(0,0,0,0,0,0,0,0,  Z,Z,0,0,  0,32'h300,0);

    begin
      int budget;
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_queue: got %0d pending required 0", q.size());
      end
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
